// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer.
// Holds the FSM state encoding, the default note-entry field widths and
// amplitude, the note half-period constants for a 50 MHz clock, and a helper
// that maps the tone phase onto a signed square-wave level.
package melody_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_PLAY = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_PLAY = ST_PLAY,
        S_GAP  = ST_GAP,
        S_DONE = ST_DONE
    } state_t;

    // Note entry is {half_period, dur}; dur occupies the low bits
    localparam int unsigned PERIOD_W_DEF = 21;
    localparam int unsigned DUR_W_DEF    = 8;

    localparam logic [31:0] AMPLITUDE_DEF = 32'd10000000;

    // Half periods in CLOCK_50 cycles
    localparam int unsigned CLK_HZ = 50_000_000;
    localparam int unsigned HP_C4  = CLK_HZ / (2 * 262);
    localparam int unsigned HP_C5  = CLK_HZ / (2 * 523);
    localparam int unsigned HP_D5  = CLK_HZ / (2 * 587);
    localparam int unsigned HP_E5  = CLK_HZ / (2 * 659);

    // Phase 0 is the positive half of the square wave
    function automatic logic [31:0] square_level(input logic phase, input logic [31:0] amp);
        return phase ? (~amp + 32'd1) : amp;
    endfunction

endpackage

// File: rtl/melody_note_rom.sv
// Note table lookup: idx -> {half_period, dur}.
// Ports: idx (table index), half_period (0 = rest), dur (beats, 0 = end of song).
// SONG selects the table: 0 = on-board melody, 1 = short terminated tune,
// 2 = full-depth table without a terminator.
module melody_note_rom
    import melody_pkg::*;
#(
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned PERIOD_W = PERIOD_W_DEF,
    parameter int unsigned DUR_W    = DUR_W_DEF,
    parameter int unsigned SONG     = 0
) (
    input  logic [IDX_W-1:0]    idx,
    output logic [PERIOD_W-1:0] half_period,
    output logic [DUR_W-1:0]    dur
);

    always_comb begin
        half_period = '0;
        dur         = '0;
        case (SONG)
            1: begin
                case (idx)
                    IDX_W'(0): begin half_period = PERIOD_W'(3); dur = DUR_W'(2); end
                    IDX_W'(1): begin half_period = '0;           dur = DUR_W'(1); end
                    IDX_W'(2): begin half_period = PERIOD_W'(5); dur = DUR_W'(1); end
                    default:   begin half_period = '0;           dur = '0;        end
                endcase
            end
            2: begin
                half_period = PERIOD_W'(idx) + PERIOD_W'(2);
                dur         = DUR_W'(1);
            end
            default: begin
                case (idx)
                    IDX_W'(0): begin half_period = PERIOD_W'(HP_C4); dur = DUR_W'(250); end
                    IDX_W'(1): begin half_period = PERIOD_W'(HP_C5); dur = DUR_W'(250); end
                    IDX_W'(2): begin half_period = PERIOD_W'(HP_D5); dur = DUR_W'(250); end
                    IDX_W'(3): begin half_period = PERIOD_W'(HP_E5); dur = DUR_W'(250); end
                    IDX_W'(4): begin half_period = '0;               dur = DUR_W'(125); end
                    IDX_W'(5): begin half_period = PERIOD_W'(HP_E5); dur = DUR_W'(250); end
                    IDX_W'(6): begin half_period = PERIOD_W'(HP_D5); dur = DUR_W'(250); end
                    IDX_W'(7): begin half_period = PERIOD_W'(HP_C5); dur = DUR_W'(250); end
                    default:   begin half_period = '0;               dur = '0;          end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/melody_sequencer.sv
// Single-voice square-wave melody player feeding Audio_Controller.
// Steps through the note ROM, times each note and the silent gap after it on
// a wall-clock beat, and presents signed samples on both audio channels.
// Ports:
//   CLOCK_50, reset            clock, asynchronous active-high reset
//   start, stop, loop          song control (stop wins over start)
//   audio_out_allowed          Audio_Controller FIFO has room
//   write_audio_out            sample write strobe (combinational)
//   sample, left/right_channel_audio_out   signed 32-bit sample
//   note_idx, busy, done       current index, song active, natural-end pulse
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int unsigned NUM_NOTES = 16,
    parameter int unsigned PERIOD_W  = PERIOD_W_DEF,
    parameter int unsigned DUR_W     = DUR_W_DEF,
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned GAP_BEATS = 10,
    parameter logic [31:0] AMPLITUDE = AMPLITUDE_DEF,
    parameter int unsigned SONG      = 0,
    localparam int unsigned IDX_W    = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic               audio_out_allowed,
    output logic               write_audio_out,
    output logic signed [31:0] sample,
    output logic signed [31:0] left_channel_audio_out,
    output logic signed [31:0] right_channel_audio_out,
    output logic [IDX_W-1:0]   note_idx,
    output logic               busy,
    output logic               done
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GAP_W  = (GAP_BEATS > 0) ? $clog2(GAP_BEATS + 1) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_NOTES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_BEATS - 1);

    state_t              state;
    logic [PERIOD_W-1:0] half_period;
    logic [DUR_W-1:0]    dur;
    logic [PERIOD_W-1:0] tone_cnt;
    logic [DUR_W-1:0]    beat_cnt;
    logic [TICK_W-1:0]   tick_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic                phase;

    logic [PERIOD_W-1:0] rom_hp;
    logic [DUR_W-1:0]    rom_dur;

    logic                tone_wrap;
    logic                next_phase;
    logic                tick_last;
    state_t              adv_state;
    logic [IDX_W-1:0]    adv_idx;

    melody_note_rom #(
        .IDX_W    (IDX_W),
        .PERIOD_W (PERIOD_W),
        .DUR_W    (DUR_W),
        .SONG     (SONG)
    ) u_rom (
        .idx         (note_idx),
        .half_period (rom_hp),
        .dur         (rom_dur)
    );

    // Tone and beat counter terminal conditions
    always_comb begin
        tone_wrap  = (tone_cnt == (half_period - PERIOD_W'(1)));
        next_phase = phase ^ tone_wrap;
        tick_last  = (tick_cnt == TICK_LAST);
    end

    // Advance step: next index, wrap on loop, or finish at the table end
    always_comb begin
        adv_state = S_LOAD;
        adv_idx   = note_idx + IDX_W'(1);
        if (note_idx == LAST_IDX) begin
            adv_idx = '0;
            if (!loop) begin
                adv_state = S_DONE;
            end
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            half_period <= '0;
            dur         <= '0;
            tone_cnt    <= '0;
            beat_cnt    <= '0;
            tick_cnt    <= '0;
            gap_cnt     <= '0;
            phase       <= 1'b0;
            sample      <= '0;
            note_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= S_IDLE;
                tone_cnt <= '0;
                beat_cnt <= '0;
                tick_cnt <= '0;
                gap_cnt  <= '0;
                phase    <= 1'b0;
                sample   <= '0;
                note_idx <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        sample   <= '0;
                        note_idx <= '0;
                        if (start) begin
                            state <= S_LOAD;
                            busy  <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        half_period <= rom_hp;
                        dur         <= rom_dur;
                        tone_cnt    <= '0;
                        beat_cnt    <= '0;
                        tick_cnt    <= '0;
                        gap_cnt     <= '0;
                        phase       <= 1'b0;
                        if (rom_dur == '0) begin
                            state    <= S_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            note_idx <= '0;
                            sample   <= '0;
                        end else begin
                            state  <= S_PLAY;
                            sample <= (rom_hp == '0) ? '0 : AMPLITUDE;
                        end
                    end
                    S_PLAY: begin
                        if (tone_wrap) begin
                            tone_cnt <= '0;
                        end else begin
                            tone_cnt <= tone_cnt + PERIOD_W'(1);
                        end
                        phase  <= next_phase;
                        sample <= (half_period == '0) ? '0 : square_level(next_phase, AMPLITUDE);
                        if (tick_last) begin
                            tick_cnt <= '0;
                            if (beat_cnt == (dur - DUR_W'(1))) begin
                                beat_cnt <= '0;
                                sample   <= '0;
                                if (GAP_BEATS == 0) begin
                                    state    <= adv_state;
                                    note_idx <= adv_idx;
                                    busy     <= (adv_state == S_LOAD);
                                    done     <= (adv_state == S_DONE);
                                end else begin
                                    state <= S_GAP;
                                end
                            end else begin
                                beat_cnt <= beat_cnt + DUR_W'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                    S_GAP: begin
                        sample <= '0;
                        if (tick_last) begin
                            tick_cnt <= '0;
                            if (gap_cnt == GAP_LAST) begin
                                gap_cnt  <= '0;
                                state    <= adv_state;
                                note_idx <= adv_idx;
                                busy     <= (adv_state == S_LOAD);
                                done     <= (adv_state == S_DONE);
                            end else begin
                                gap_cnt <= gap_cnt + GAP_W'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                    S_DONE: begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        note_idx <= '0;
                        sample   <= '0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sequencing never waits on the FIFO; unaccepted samples are dropped
    assign write_audio_out         = audio_out_allowed & busy;
    assign left_channel_audio_out  = sample;
    assign right_channel_audio_out = sample;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer using small test tables.
module tb_melody_sequencer;

    localparam int TICK = 4;
    localparam int GAP  = 1;
    localparam logic [31:0] POS = 32'd100;
    localparam logic [31:0] NEG = 32'hFFFF_FF9C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, stop, loop, allowed;
    logic wr, busy, done;
    logic signed [31:0] smp, left_ch, right_ch;
    logic [3:0] idx;

    logic start_l, stop_l, loop_l;
    logic wr_l, busy_l, done_l;
    logic signed [31:0] smp_l, left_l, right_l;
    logic [3:0] idx_l;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] smp;
        logic [3:0]  idx;
        logic        idx_chk;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t q[$];

    melody_sequencer #(
        .NUM_NOTES(16), .TICK_DIV(TICK), .GAP_BEATS(GAP),
        .AMPLITUDE(32'd100), .SONG(1)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
        .audio_out_allowed(allowed), .write_audio_out(wr), .sample(smp),
        .left_channel_audio_out(left_ch), .right_channel_audio_out(right_ch),
        .note_idx(idx), .busy(busy), .done(done)
    );

    melody_sequencer #(
        .NUM_NOTES(16), .TICK_DIV(TICK), .GAP_BEATS(GAP),
        .AMPLITUDE(32'd100), .SONG(2)
    ) dut_loop (
        .CLOCK_50(clk), .reset(reset), .start(start_l), .stop(stop_l), .loop(loop_l),
        .audio_out_allowed(1'b1), .write_audio_out(wr_l), .sample(smp_l),
        .left_channel_audio_out(left_l), .right_channel_audio_out(right_l),
        .note_idx(idx_l), .busy(busy_l), .done(done_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle response of one table entry: LOAD, PLAY, GAP
    task automatic push_note(input int n, input int hp, input int dur);
        exp_t e;
        e.smp = '0; e.idx = 4'(n); e.idx_chk = 1'b1; e.busy = 1'b1; e.done = 1'b0;
        q.push_back(e);
        if (dur == 0) begin
            e.idx_chk = 1'b0; e.busy = 1'b0; e.done = 1'b1;
            q.push_back(e);
            return;
        end
        for (int c = 0; c < dur * TICK; c++) begin
            e.smp = (hp == 0) ? 32'd0 : ((((c / hp) % 2) != 0) ? NEG : POS);
            q.push_back(e);
        end
        e.smp = '0;
        for (int c = 0; c < GAP * TICK; c++) q.push_back(e);
    endtask

    task automatic push_song();
        exp_t e;
        push_note(0, 3, 2);
        push_note(1, 0, 1);
        push_note(2, 5, 1);
        push_note(3, 0, 0);
        e.smp = '0; e.idx = '0; e.idx_chk = 1'b1; e.busy = 1'b0; e.done = 1'b0;
        q.push_back(e);
    endtask

    // Pops one expectation per cycle; optionally drops allowed and pulses start
    task automatic run_queue(input int off_from, input int off_len, input int start_a, input int start_b);
        int cyc;
        exp_t e;
        logic al;
        cyc = 0;
        while (q.size() > 0) begin
            edge_wait();
            al = !(cyc >= off_from && cyc < off_from + off_len);
            allowed = al;
            start = (cyc == start_a || cyc == start_b);
            #1;
            e = q.pop_front();
            chk("sample", smp, e.smp);
            chk("left", left_ch, e.smp);
            chk("right", right_ch, e.smp);
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("write", 32'(wr), 32'(e.busy & al));
            if (e.idx_chk) chk("note_idx", 32'(idx), 32'(e.idx));
            cyc++;
        end
        start = 1'b0;
        allowed = 1'b1;
    endtask

    initial begin
        int done_pos;
        int done_seen;
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; allowed = 1'b1;
        start_l = 1'b0; stop_l = 1'b0; loop_l = 1'b1;
        edge_wait();
        edge_wait();
        chk("rst_sample", smp, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_write", 32'(wr), 32'd0);
        reset = 1'b0;
        edge_wait();

        // Full song
        push_song();
        start = 1'b1;
        run_queue(1000, 0, -1, -1);

        // Handshake dropped for 5 cycles mid-note; timing unchanged
        push_song();
        start = 1'b1;
        run_queue(4, 5, -1, -1);

        // start while busy and in the DONE cycle are ignored
        push_song();
        done_pos = q.size() - 2;
        start = 1'b1;
        run_queue(1000, 0, 10, done_pos);
        edge_wait(); #1;
        chk("done_start_busy", 32'(busy), 32'd0);

        // start and stop together from IDLE
        start = 1'b1; stop = 1'b1;
        edge_wait();
        start = 1'b0; stop = 1'b0;
        #1;
        chk("startstop_busy", 32'(busy), 32'd0);
        edge_wait(); #1;
        chk("startstop_busy2", 32'(busy), 32'd0);
        chk("startstop_sample", smp, 32'd0);

        // stop in the third PLAY cycle of note 0
        start = 1'b1;
        edge_wait();
        start = 1'b0;
        #1;
        chk("stop_load_busy", 32'(busy), 32'd1);
        edge_wait(); #1;
        chk("stop_play1", smp, POS);
        edge_wait(); #1;
        chk("stop_play2", smp, POS);
        edge_wait();
        stop = 1'b1;
        #1;
        chk("stop_play3", smp, POS);
        edge_wait();
        stop = 1'b0;
        #1;
        chk("stop_sample", smp, 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        chk("stop_idx", 32'(idx), 32'd0);
        edge_wait(); #1;
        chk("stop_after_done", 32'(done), 32'd0);
        chk("stop_after_busy", 32'(busy), 32'd0);
        push_song();
        start = 1'b1;
        run_queue(1000, 0, -1, -1);

        // Asynchronous reset mid-PLAY
        start = 1'b1;
        edge_wait();
        start = 1'b0;
        edge_wait();
        edge_wait();
        #1;
        chk("pre_reset_sample", smp, POS);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_sample", smp, 32'd0);
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_idx", 32'(idx), 32'd0);
        chk("areset_write", 32'(wr), 32'd0);
        edge_wait();
        reset = 1'b0;
        edge_wait(); #1;
        chk("post_reset_busy", 32'(busy), 32'd0);

        // Looping 16-entry table: index wraps to 0 after entry 15's gap
        done_seen = 0;
        start_l = 1'b1;
        edge_wait();
        start_l = 1'b0;
        #1;
        for (int n = 0; n <= 16; n++) begin
            chk("loop_idx", 32'(idx_l), 32'(n % 16));
            chk("loop_busy", 32'(busy_l), 32'd1);
            chk("loop_load_sample", smp_l, 32'd0);
            for (int c = 0; c < 1 + (1 + GAP) * TICK; c++) begin
                if (done_l) done_seen++;
                edge_wait(); #1;
            end
        end
        chk("loop_no_done", 32'(done_seen), 32'd0);
        stop_l = 1'b1;
        edge_wait();
        stop_l = 1'b0;
        #1;
        chk("loop_stop_busy", 32'(busy_l), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
